// File: rtl/li_fifo_pkg.sv
// Shared constants and sizing helpers for the latency-insensitive shell FIFO.
package li_fifo_pkg;

    localparam int SHOWAHEAD_ON  = 1;
    localparam int SHOWAHEAD_OFF = 0;

    // One extra bit so a full FIFO (count == DEPTH) is distinct from empty.
    function automatic int count_width(input int fifo_addr);
        return fifo_addr + 1;
    endfunction

    // Backpressure must leave room for the words already in flight upstream.
    function automatic int af_threshold(input int depth, input int ready_latency);
        return depth - ready_latency;
    endfunction

endpackage

// File: rtl/li_fifo_mem.sv
// Register-array FIFO storage: synchronous write port, asynchronous read port.
module li_fifo_mem
    import li_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_ADDR  = 4
) (
    input  logic                         clock,
    input  logic                         i_we,
    input  logic [FIFO_ADDR-1:0]         i_waddr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    input  logic [FIFO_ADDR-1:0]         i_raddr,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << FIFO_ADDR;

    logic signed [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Contents are deliberately unreset; pointers in the top define validity.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/li_fifo_param.sv
// Parametrised single-clock FIFO with show-ahead or registered read, occupancy
// count, READY_LATENCY-derived almost-full and sticky overflow/underflow flags.
module li_fifo_param
    import li_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_ADDR     = 4,
    parameter int READY_LATENCY = 2,
    parameter int SHOWAHEAD     = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_enq,
    input  logic                         i_deq,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic [FIFO_ADDR:0]           o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int DEPTH = 1 << FIFO_ADDR;
    localparam int CNT_W = count_width(FIFO_ADDR);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF_TH = CNT_W'(af_threshold(DEPTH, READY_LATENCY));

    if (READY_LATENCY >= DEPTH || READY_LATENCY < 0) begin : g_err_rl
        $error("li_fifo_param: READY_LATENCY must be in 0..DEPTH-1");
    end
    if (FIFO_ADDR < 1) begin : g_err_addr
        $error("li_fifo_param: FIFO_ADDR must be at least 1");
    end
    if (DATA_WIDTH < 1) begin : g_err_dw
        $error("li_fifo_param: DATA_WIDTH must be at least 1");
    end
    if (SHOWAHEAD != SHOWAHEAD_ON && SHOWAHEAD != SHOWAHEAD_OFF) begin : g_err_sa
        $error("li_fifo_param: SHOWAHEAD must be 0 or 1");
    end

    logic [FIFO_ADDR-1:0]         r_wptr;
    logic [FIFO_ADDR-1:0]         r_rptr;
    logic [CNT_W-1:0]             r_count;
    logic                         r_empty;
    logic                         r_afull;
    logic                         r_ovf;
    logic                         r_udf;

    logic                         w_deq_ok;
    logic                         w_enq_ok;
    logic [CNT_W-1:0]             w_count_next;
    logic signed [DATA_WIDTH-1:0] w_rdata;

    // A full FIFO still accepts a write when a read frees a slot in the same
    // cycle; an empty FIFO never forwards the incoming word to the reader.
    assign w_deq_ok     = i_deq & (r_count != '0);
    assign w_enq_ok     = i_enq & ((r_count != C_DEPTH) | w_deq_ok);
    assign w_count_next = r_count + CNT_W'(w_enq_ok) - CNT_W'(w_deq_ok);

    li_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_ADDR  (FIFO_ADDR)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_enq_ok),
        .i_waddr (r_wptr),
        .i_wdata (i_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_enq_ok) begin
                r_wptr <= r_wptr + FIFO_ADDR'(1);
            end
            if (w_deq_ok) begin
                r_rptr <= r_rptr + FIFO_ADDR'(1);
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_afull <= (w_count_next >= C_AF_TH);
            r_ovf   <= r_ovf | (i_enq & ~w_enq_ok);
            r_udf   <= r_udf | (i_deq & ~w_deq_ok);
        end
    end

    assign o_empty       = r_empty;
    assign o_almost_full = r_afull;
    assign o_count       = r_count;
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_udf;

    if (SHOWAHEAD == SHOWAHEAD_ON) begin : g_showahead
        assign o_data  = w_rdata;
        assign o_valid = ~r_empty;
    end else begin : g_registered
        logic signed [DATA_WIDTH-1:0] r_data_p1;
        logic                         r_valid_p1;

        // Read stage: the head word is captured on an accepted dequeue.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_data_p1  <= '0;
                r_valid_p1 <= 1'b0;
            end else begin
                r_valid_p1 <= w_deq_ok;
                if (w_deq_ok) begin
                    r_data_p1 <= w_rdata;
                end
            end
        end

        assign o_data  = r_data_p1;
        assign o_valid = r_valid_p1;
    end

endmodule

// File: tb/tb_li_fifo_param.sv
// Bench for li_fifo_param: a show-ahead and a registered-read instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_li_fifo_param;

    localparam int DW    = 32;
    localparam int FA    = 4;
    localparam int DEPTH = 16;
    localparam int RL    = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] i_data = '0;
    logic                 i_enq = 1'b0;
    logic                 i_deq = 1'b0;

    logic signed [DW-1:0] sa_data, rg_data;
    logic                 sa_valid, rg_valid, sa_empty, rg_empty;
    logic                 sa_af, rg_af, sa_ovf, rg_ovf, sa_udf, rg_udf;
    logic [FA:0]          sa_count, rg_count;

    li_fifo_param #(.DATA_WIDTH(DW), .FIFO_ADDR(FA), .READY_LATENCY(RL), .SHOWAHEAD(1)) u_sa (
        .clock(clock), .reset(reset), .i_data(i_data), .i_enq(i_enq), .i_deq(i_deq),
        .o_data(sa_data), .o_valid(sa_valid), .o_empty(sa_empty), .o_almost_full(sa_af),
        .o_count(sa_count), .o_overflow(sa_ovf), .o_underflow(sa_udf)
    );

    li_fifo_param #(.DATA_WIDTH(DW), .FIFO_ADDR(FA), .READY_LATENCY(RL), .SHOWAHEAD(0)) u_rg (
        .clock(clock), .reset(reset), .i_data(i_data), .i_enq(i_enq), .i_deq(i_deq),
        .o_data(rg_data), .o_valid(rg_valid), .o_empty(rg_empty), .o_almost_full(rg_af),
        .o_count(rg_count), .o_overflow(rg_ovf), .o_underflow(rg_udf)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the FIFO contents as a plain queue.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_udf, m_rvalid;
    logic [DW-1:0] m_rdata;

    typedef struct {
        bit            enq;
        bit            deq;
        logic [DW-1:0] data;
        int            exp_count;
        bit            exp_udf;
        bit            chk_head;
        logic [DW-1:0] exp_head;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic model_check();
        int  n;
        bit  af;
        n  = q.size();
        af = (n >= DEPTH - RL);
        chk("sa_count", DW'(sa_count), DW'(n));
        chk("rg_count", DW'(rg_count), DW'(n));
        chk("sa_empty", DW'(sa_empty), DW'(n == 0));
        chk("rg_empty", DW'(rg_empty), DW'(n == 0));
        chk("sa_almost_full", DW'(sa_af), DW'(af));
        chk("rg_almost_full", DW'(rg_af), DW'(af));
        chk("sa_overflow", DW'(sa_ovf), DW'(m_ovf));
        chk("rg_overflow", DW'(rg_ovf), DW'(m_ovf));
        chk("sa_underflow", DW'(sa_udf), DW'(m_udf));
        chk("rg_underflow", DW'(rg_udf), DW'(m_udf));
        chk("sa_valid", DW'(sa_valid), DW'(n != 0));
        if (n != 0) chk("sa_head", sa_data, q[0]);
        chk("rg_valid", DW'(rg_valid), DW'(m_rvalid));
        chk("rg_data", rg_data, m_rdata);
    endtask

    // One clock: drive request, let the edge happen, advance model, compare.
    task automatic cycle(input bit enq, input bit deq, input logic [DW-1:0] d);
        bit dok, eok;
        dok    = deq && (q.size() != 0);
        eok    = enq && ((q.size() < DEPTH) || dok);
        i_enq  = enq;
        i_deq  = deq;
        i_data = d;
        @(posedge clock);
        #1;
        i_enq = 1'b0;
        i_deq = 1'b0;
        if (deq && !dok) m_udf = 1'b1;
        if (enq && !eok) m_ovf = 1'b1;
        if (dok) begin
            m_rdata  = q.pop_front();
            m_rvalid = 1'b1;
        end else begin
            m_rvalid = 1'b0;
        end
        if (eok) q.push_back(d);
        model_check();
    endtask

    // Reset raised between edges and checked before the next edge arrives.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        model_check();
        chk("rst_sa_count", DW'(sa_count), '0);
        chk("rst_rg_data", rg_data, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h11, 1, 1'b0, 1'b1, 32'h11};
        vecs[1] = '{1'b1, 1'b0, 32'h22, 2, 1'b0, 1'b1, 32'h11};
        vecs[2] = '{1'b1, 1'b0, 32'h33, 3, 1'b0, 1'b1, 32'h11};
        vecs[3] = '{1'b0, 1'b1, 32'h00, 2, 1'b0, 1'b1, 32'h22};
        vecs[4] = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b1, 32'h33};
        vecs[5] = '{1'b0, 1'b1, 32'h00, 0, 1'b0, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 32'h00};

        model_clear();
        repeat (2) @(posedge clock);
        #1;
        model_check();
        reset = 1'b0;
        cycle(1'b0, 1'b0, '0);
        chk("idle_empty", DW'(sa_empty), 1);
        chk("idle_valid", DW'(rg_valid), 0);

        // Directed table: three words in, three out, then a read on empty.
        foreach (vecs[i]) begin
            cycle(vecs[i].enq, vecs[i].deq, vecs[i].data);
            chk($sformatf("vec%0d_count", i), DW'(sa_count), DW'(vecs[i].exp_count));
            chk($sformatf("vec%0d_empty", i), DW'(sa_empty), DW'(vecs[i].exp_count == 0));
            chk($sformatf("vec%0d_udf", i), DW'(sa_udf), DW'(vecs[i].exp_udf));
            if (vecs[i].chk_head) chk($sformatf("vec%0d_head", i), sa_data, vecs[i].exp_head);
        end

        // Fill to almost-full, full, then overflow.
        async_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, 32'h100 + i);
            chk("af_fill", DW'(sa_af), DW'(i == 13));
        end
        chk("af_count14", DW'(sa_count), 14);
        cycle(1'b1, 1'b0, 32'h10E);
        cycle(1'b1, 1'b0, 32'h10F);
        chk("full_count", DW'(sa_count), 16);
        chk("full_no_ovf", DW'(sa_ovf), 0);
        cycle(1'b1, 1'b0, 32'hDEAD);
        chk("ovf_set", DW'(sa_ovf), 1);
        chk("ovf_count", DW'(sa_count), 16);
        cycle(1'b0, 1'b0, '0);
        chk("ovf_sticky", DW'(rg_ovf), 1);

        // Full with simultaneous enq+deq, drain, then enq+deq on empty.
        async_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h200 + i);
        cycle(1'b1, 1'b1, 32'h2FF);
        chk("fullrw_count", DW'(sa_count), 16);
        chk("fullrw_head", sa_data, 32'h201);
        chk("fullrw_ovf", DW'(sa_ovf), 0);
        chk("fullrw_rdata", rg_data, 32'h200);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        chk("drained_last", rg_data, 32'h2FF);
        cycle(1'b1, 1'b1, 32'h77);
        chk("emptyrw_udf", DW'(sa_udf), 1);
        chk("emptyrw_count", DW'(sa_count), 1);
        chk("emptyrw_head", sa_data, 32'h77);

        // Registered read: one-cycle valid pulse, data holds afterwards.
        async_reset();
        cycle(1'b1, 1'b0, 32'h5A);
        chk("rg_pre_valid", DW'(rg_valid), 0);
        cycle(1'b0, 1'b1, '0);
        chk("rg_pulse_valid", DW'(rg_valid), 1);
        chk("rg_pulse_data", rg_data, 32'h5A);
        cycle(1'b0, 1'b0, '0);
        chk("rg_drop_valid", DW'(rg_valid), 0);
        chk("rg_hold_data", rg_data, 32'h5A);

        // Random traffic with a mid-stream asynchronous reset.
        async_reset();
        for (int i = 0; i < 160; i++) begin
            if (i == 100) async_reset();
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
